// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and defaults for the fetch front end
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_KILL = 2'd2,
    ST_DONE = 2'd3
  } fetch_state_t;

  localparam int DEFAULT_PC_STEP  = 4;
  localparam int DEFAULT_RESET_PC = 0;

  // Queue entries are packed as {pc, instr}
  function automatic int entry_width(input int pc_width, input int iwidth);
    return pc_width + iwidth;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO holding {pc, instr} fetch entries
module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     clear,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match
  assign count     = wr_ptr - rd_ptr;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_queue_stage.sv
// rtl/fetch_queue_stage.sv - sequential instruction fetch with redirect/flush and a decode-side queue
module fetch_queue_stage
  import fetch_pkg::*;
#(
  parameter int IWIDTH   = 32,
  parameter int PC_WIDTH = 32,
  parameter int QDEPTH   = 4,
  parameter int PC_STEP  = DEFAULT_PC_STEP,
  parameter int RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                      fq_clk,
  input  logic                      fq_rst,
  input  logic                      fq_i_ce,
  input  logic                      fq_change_pc,
  input  logic [PC_WIDTH-1:0]       fq_alu_pc_value,
  input  logic                      fq_i_flush,
  input  logic                      fq_i_stall,
  output logic                      fq_o_syn,
  output logic [PC_WIDTH-1:0]       fq_o_addr_instr,
  input  logic                      fq_i_ack,
  input  logic [IWIDTH-1:0]         fq_i_instr,
  input  logic                      fq_i_last,
  output logic [IWIDTH-1:0]         fq_o_instr,
  output logic [PC_WIDTH-1:0]       fq_pc,
  output logic                      fq_o_ce,
  output logic                      fq_o_stall,
  output logic                      fq_o_flush,
  output logic [$clog2(QDEPTH):0]   fq_o_count
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int EW = entry_width(PC_WIDTH, IWIDTH);

  fetch_state_t      state;
  logic [PC_WIDTH-1:0] fetch_pc;
  logic              redirect;
  logic              credit_ok;
  logic              push;
  logic [EW-1:0]     head;
  logic [CW-1:0]     count;
  logic              q_full;
  logic              q_empty;

  assign redirect   = fq_change_pc | fq_i_flush;
  assign credit_ok  = (count < CW'(QDEPTH));
  assign push       = (state == ST_REQ) && fq_i_ack && !redirect;
  assign fq_o_ce    = !q_empty && !fq_i_stall && !redirect;
  assign fq_o_stall = q_full;
  assign fq_o_count = count;
  assign fq_pc      = head[EW-1 -: PC_WIDTH];
  assign fq_o_instr = head[IWIDTH-1:0];

  fetch_queue #(
    .WIDTH (EW),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk       (fq_clk),
    .rst       (fq_rst),
    .push      (push),
    .push_data ({fetch_pc, fq_i_instr}),
    .pop       (fq_o_ce),
    .clear     (redirect),
    .head_data (head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (count)
  );

  always_ff @(posedge fq_clk) begin
    if (fq_rst) begin
      state           <= ST_IDLE;
      fetch_pc        <= PC_WIDTH'(RESET_PC);
      fq_o_addr_instr <= PC_WIDTH'(RESET_PC);
      fq_o_syn        <= 1'b0;
      fq_o_flush      <= 1'b0;
    end else begin
      fq_o_flush <= redirect;
      if (redirect) begin
        if (fq_change_pc) begin
          fetch_pc <= fq_alu_pc_value;
        end
        // An in-flight request must still be acked by memory, so it is parked in KILL
        if (state == ST_REQ || state == ST_KILL) begin
          if (fq_i_ack) begin
            state    <= ST_IDLE;
            fq_o_syn <= 1'b0;
          end else begin
            state <= ST_KILL;
          end
        end else begin
          state <= ST_IDLE;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (fq_i_ce && credit_ok) begin
              state           <= ST_REQ;
              fq_o_syn        <= 1'b1;
              fq_o_addr_instr <= fetch_pc;
            end
          end
          ST_REQ: begin
            if (fq_i_ack) begin
              fetch_pc <= fetch_pc + PC_WIDTH'(PC_STEP);
              fq_o_syn <= 1'b0;
              state    <= fq_i_last ? ST_DONE : ST_IDLE;
            end
          end
          ST_KILL: begin
            if (fq_i_ack) begin
              fq_o_syn <= 1'b0;
              state    <= ST_IDLE;
            end
          end
          default: begin
            state <= ST_DONE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb/tb_fetch_queue_stage.sv - directed self-checking bench for fetch_queue_stage
module tb_fetch_queue_stage;

  logic        clk = 1'b0;
  logic        rst, ce, change_pc, flush, stall, ack, last;
  logic [31:0] alu, instr_in;
  logic        syn, o_ce, o_stall, o_flush;
  logic [31:0] addr, o_instr, pc;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  logic        mem_en = 1'b1;
  int          mem_delay = 0;
  logic [31:0] mem_last_addr = 32'hFFFF_FFFF;

  logic [31:0] req_addr[$];
  int          req_cyc[$];
  logic [63:0] popped[$];
  int          cyc = 0;
  logic        prev_syn = 1'b0;

  typedef struct {
    int                delay;
    logic [31:0]       start;
    logic [3:0][31:0]  pcs;
    int                gap;
  } row_t;

  row_t rows[4];

  always #5 clk = ~clk;

  fetch_queue_stage #(
    .IWIDTH   (32),
    .PC_WIDTH (32),
    .QDEPTH   (4),
    .PC_STEP  (4),
    .RESET_PC (0)
  ) dut (
    .fq_clk          (clk),
    .fq_rst          (rst),
    .fq_i_ce         (ce),
    .fq_change_pc    (change_pc),
    .fq_alu_pc_value (alu),
    .fq_i_flush      (flush),
    .fq_i_stall      (stall),
    .fq_o_syn        (syn),
    .fq_o_addr_instr (addr),
    .fq_i_ack        (ack),
    .fq_i_instr      (instr_in),
    .fq_i_last       (last),
    .fq_o_instr      (o_instr),
    .fq_pc           (pc),
    .fq_o_ce         (o_ce),
    .fq_o_stall      (o_stall),
    .fq_o_flush      (o_flush),
    .fq_o_count      (count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory model: ack in syn cycle number mem_delay (0 = first syn cycle)
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_en) begin
        ack  = 1'b0;
        last = 1'b0;
        if (syn) begin
          if (wait_cnt == mem_delay) begin
            ack      = 1'b1;
            instr_in = mem_word(addr);
            last     = (addr == mem_last_addr);
            wait_cnt = 0;
          end else begin
            wait_cnt++;
          end
        end else begin
          wait_cnt = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (syn && !prev_syn) begin
      req_addr.push_back(addr);
      req_cyc.push_back(cyc);
    end
    prev_syn = syn;
    if (o_ce) popped.push_back({pc, o_instr});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic wait_syn(input logic want, input string nm);
    int n;
    n = 0;
    while (syn !== want && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) check(nm, syn, want);
  endtask

  task automatic wait_pops(input int want, input string nm);
    int n;
    n = 0;
    while (popped.size() < want && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) check(nm, popped.size(), want);
  endtask

  task automatic wait_reqs(input int want, input string nm);
    int n;
    n = 0;
    while (req_addr.size() < want && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) check(nm, req_addr.size(), want);
  endtask

  task automatic redirect(input logic [31:0] target);
    change_pc = 1'b1;
    alu       = target;
    step();
    change_pc = 1'b0;
    samp();
    check("flush_pulse", o_flush, 1'b1);
    step();
    samp();
    check("flush_drop", o_flush, 1'b0);
    step();
  endtask

  task automatic clear_logs();
    req_addr.delete();
    req_cyc.delete();
    popped.delete();
  endtask

  initial begin
    int n;
    rows[0] = '{delay: 2, start: 32'h0,         pcs: {32'hC, 32'h8, 32'h4, 32'h0},                         gap: 4};
    rows[1] = '{delay: 0, start: 32'h100,       pcs: {32'h10C, 32'h108, 32'h104, 32'h100},                 gap: 2};
    rows[2] = '{delay: 1, start: 32'hFFFF_FFF8, pcs: {32'h4, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFF8},         gap: 3};
    rows[3] = '{delay: 3, start: 32'h40,        pcs: {32'h4C, 32'h48, 32'h44, 32'h40},                     gap: 5};

    rst = 1'b1; ce = 1'b0; change_pc = 1'b0; flush = 1'b0; stall = 1'b0;
    ack = 1'b0; last = 1'b0; alu = '0; instr_in = '0;
    repeat (3) step();
    rst = 1'b0;
    samp();
    check("rst_syn", syn, 1'b0);
    check("rst_addr", addr, 32'h0);
    check("rst_count", count, 3'd0);
    check("rst_oce", o_ce, 1'b0);
    check("rst_flush", o_flush, 1'b0);
    check("rst_stall", o_stall, 1'b0);
    check("rst_instr", o_instr, 32'h0);
    check("rst_pc", pc, 32'h0);
    step();

    for (int r = 0; r < 4; r++) begin
      ce = 1'b0;
      wait_syn(1'b0, "row_idle");
      if (r != 0) redirect(rows[r].start);
      clear_logs();
      mem_delay = rows[r].delay;
      ce = 1'b1;
      wait_pops(4, "row_pops");
      for (int i = 0; i < 4; i++) begin
        if (req_addr.size() > i) check($sformatf("row%0d_req%0d", r, i), req_addr[i], rows[r].pcs[i]);
        else check($sformatf("row%0d_req%0d_missing", r, i), req_addr.size(), i + 1);
        if (popped.size() > i) begin
          check($sformatf("row%0d_pc%0d", r, i), popped[i][63:32], rows[r].pcs[i]);
          check($sformatf("row%0d_instr%0d", r, i), popped[i][31:0], mem_word(rows[r].pcs[i]));
        end
      end
      if (req_cyc.size() > 1) check($sformatf("row%0d_gap", r), req_cyc[1] - req_cyc[0], rows[r].gap);
    end

    // Downstream stall fills the queue exactly, then drains one per cycle
    ce = 1'b0;
    wait_syn(1'b0, "stall_idle");
    stall = 1'b1;
    redirect(32'h200);
    clear_logs();
    mem_delay = 0;
    ce = 1'b1;
    repeat (40) step();
    samp();
    check("full_count", count, 3'd4);
    check("full_stall", o_stall, 1'b1);
    check("full_nosyn", syn, 1'b0);
    check("full_reqs", req_addr.size(), 4);
    check("full_oce", o_ce, 1'b0);
    step();
    stall = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      samp();
      if (o_ce) n++;
      step();
    end
    check("drain_rate", n, 4);
    for (int i = 0; i < 4; i++) begin
      if (popped.size() > i) check($sformatf("drain_pc%0d", i), popped[i][63:32], 32'h200 + 32'(4 * i));
    end
    wait_reqs(5, "resume_req");
    if (req_addr.size() > 4) check("resume_addr", req_addr[4], 32'h210);
    ce = 1'b0;
    wait_syn(1'b0, "resume_idle");

    // Last instruction stops fetching until a redirect
    stall = 1'b1;
    mem_delay = 1;
    mem_last_addr = 32'h8;
    redirect(32'h0);
    clear_logs();
    ce = 1'b1;
    repeat (30) step();
    samp();
    check("done_count", count, 3'd3);
    check("done_nosyn", syn, 1'b0);
    check("done_reqs", req_addr.size(), 3);
    step();
    stall = 1'b0;
    repeat (8) step();
    samp();
    check("done_drained", count, 3'd0);
    check("done_pops", popped.size(), 3);
    if (popped.size() > 2) check("done_last_pc", popped[2][63:32], 32'h8);
    check("done_still_reqs", req_addr.size(), 3);
    step();
    redirect(32'h0);
    wait_reqs(4, "restart_req");
    if (req_addr.size() > 3) check("restart_addr", req_addr[3], 32'h0);
    ce = 1'b0;
    mem_last_addr = 32'hFFFF_FFFF;
    wait_syn(1'b0, "restart_idle");

    // Redirect while a request is outstanding, ack one cycle later
    mem_en = 1'b0;
    ack = 1'b0;
    last = 1'b0;
    redirect(32'h300);
    ce = 1'b1;
    wait_syn(1'b1, "kill_syn");
    change_pc = 1'b1;
    alu = 32'h100;
    samp();
    check("kill_old_addr", addr, 32'h300);
    step();
    change_pc = 1'b0;
    ack = 1'b1;
    instr_in = 32'hDEAD_BEEF;
    samp();
    check("kill_syn_held", syn, 1'b1);
    check("kill_addr_held", addr, 32'h300);
    check("kill_flush", o_flush, 1'b1);
    check("kill_count", count, 3'd0);
    step();
    ack = 1'b0;
    samp();
    check("kill_syn_drop", syn, 1'b0);
    check("kill_flush_drop", o_flush, 1'b0);
    check("kill_dropped", count, 3'd0);
    step();
    samp();
    check("kill_new_syn", syn, 1'b1);
    check("kill_new_addr", addr, 32'h100);
    ack = 1'b1;
    instr_in = mem_word(32'h100);
    step();
    ack = 1'b0;
    ce = 1'b0;
    samp();
    check("kill_push_count", count, 3'd1);
    check("kill_head_oce", o_ce, 1'b1);
    check("kill_head_pc", pc, 32'h100);
    check("kill_head_instr", o_instr, mem_word(32'h100));
    step();

    // Redirect and ack in the same cycle
    redirect(32'h400);
    ce = 1'b1;
    wait_syn(1'b1, "same_syn");
    change_pc = 1'b1;
    alu = 32'h500;
    ack = 1'b1;
    instr_in = 32'hBAD0_0000;
    step();
    change_pc = 1'b0;
    ack = 1'b0;
    samp();
    check("same_count", count, 3'd0);
    check("same_nosyn", syn, 1'b0);
    check("same_flush", o_flush, 1'b1);
    step();
    samp();
    check("same_new_syn", syn, 1'b1);
    check("same_new_addr", addr, 32'h500);
    ack = 1'b1;
    instr_in = mem_word(32'h500);
    step();
    ack = 1'b0;
    ce = 1'b0;
    samp();
    check("same_push_count", count, 3'd1);
    check("same_head_pc", pc, 32'h500);
    step();

    // Push and pop in the same cycle at count 2
    redirect(32'h600);
    stall = 1'b1;
    ce = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_syn(1'b1, "pp_syn");
      ack = 1'b1;
      instr_in = mem_word(addr);
      step();
      ack = 1'b0;
    end
    wait_syn(1'b1, "pp_syn3");
    ack = 1'b1;
    instr_in = mem_word(addr);
    stall = 1'b0;
    ce = 1'b0;
    samp();
    check("pp_oce", o_ce, 1'b1);
    check("pp_head0", pc, 32'h600);
    check("pp_count_before", count, 3'd2);
    step();
    ack = 1'b0;
    stall = 1'b1;
    samp();
    check("pp_count_after", count, 3'd2);
    check("pp_head1", pc, 32'h604);
    check("pp_oce_stalled", o_ce, 1'b0);
    step();
    stall = 1'b0;
    samp();
    check("pp_pop1_oce", o_ce, 1'b1);
    check("pp_pop1_pc", pc, 32'h604);
    step();
    samp();
    check("pp_pop2_oce", o_ce, 1'b1);
    check("pp_pop2_pc", pc, 32'h608);
    check("pp_pop2_instr", o_instr, mem_word(32'h608));
    step();
    samp();
    check("pp_empty", count, 3'd0);
    step();

    // Flush alone keeps the fetch PC
    flush = 1'b1;
    step();
    flush = 1'b0;
    samp();
    check("flush_only_pulse", o_flush, 1'b1);
    ce = 1'b1;
    wait_syn(1'b1, "flush_syn");
    check("flush_keeps_pc", addr, 32'h60C);
    ack = 1'b1;
    instr_in = mem_word(addr);
    step();
    ack = 1'b0;
    ce = 1'b0;
    samp();
    check("flush_push", count, 3'd1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
